mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_if.sv | 47 ++++
 rtl/arb_rr2.sv | 39 +++
 rtl/mem_arb.sv | 132 +++++++++++++
 tb/tb_mem_arb.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Default width of the ack-timeout counter.
    localparam int unsigned TMO_W_DEF = 8;

    // Byte enables presented for an instruction fill (always a full word).
    localparam logic [3:0] IFETCH_BE = 4'hF;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IBUSY = 2'd1,
        ST_DBUSY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Requester identity, used by the round-robin grant logic.
    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signal bundle for mem_arb.
interface mem_arb_if;

    // Instruction-fill side
    logic        ireq;
    logic [31:0] iaddr;
    logic        idone;
    logic [31:0] irdata;
    logic        istall;

    // Data side
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        ddone;
    logic [31:0] drdata;
    logic        dstall;

    // Single-port memory side
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mbe;
    logic        mack;
    logic [31:0] mrdata;

    // Sticky timeout flag
    logic        tmo_err;

    // Arbiter view
    modport slave (
        input  ireq, iaddr, dreq, dwe, daddr, dwdata, dbe, mack, mrdata,
        output idone, irdata, istall, ddone, drdata, dstall,
               mreq, mwe, maddr, mwdata, mbe, tmo_err
    );

    // Requesters plus memory view
    modport master (
        output ireq, iaddr, dreq, dwe, daddr, dwdata, dbe, mack, mrdata,
        input  idone, irdata, istall, ddone, drdata, dstall,
               mreq, mwe, maddr, mwdata, mbe, tmo_err
    );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter; on a conflict the side not granted last wins.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  ireq_i,
    input  logic  dreq_i,
    input  logic  take_i,     // grant is consumed this cycle
    output logic  valid_o,
    output side_e side_o
);

    side_e last_q;
    side_e last_d;

    // Grant decision and next value of the last-grant register.
    always_comb begin
        valid_o = ireq_i | dreq_i;
        if (ireq_i && dreq_i) begin
            side_o = (last_q == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (dreq_i) begin
            side_o = SIDE_D;
        end else begin
            side_o = SIDE_I;
        end
        last_d = (take_i && valid_o) ? side_o : last_q;
    end

    // Last-grant register; resets to I so that D wins the first conflict.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= SIDE_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates instruction fills and data accesses onto one memory port,
// with a saturating ack timeout that aborts a stuck transaction.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb_if.slave  bus
);

    state_e           state_q;
    logic             mreq_q;
    logic             mwe_q;
    logic [31:0]      maddr_q;
    logic [31:0]      mwdata_q;
    logic [3:0]       mbe_q;
    logic             idone_q;
    logic             ddone_q;
    logic [31:0]      irdata_q;
    logic [31:0]      drdata_q;
    logic             tmo_q;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    logic  gnt_valid;
    side_e gnt_side;

    arb_rr2 u_rr (
        .clk_i   (clk),
        .rst_i   (reset),
        .ireq_i  (bus.ireq),
        .dreq_i  (bus.dreq),
        .take_i  (state_q == ST_IDLE),
        .valid_o (gnt_valid),
        .side_o  (gnt_side)
    );

    // Saturating increment of the timeout counter.
    always_comb begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Arbiter FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mbe_q    <= '0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        mreq_q <= 1'b1;
                        cnt_q  <= '0;
                        if (gnt_side == SIDE_D) begin
                            maddr_q  <= bus.daddr;
                            mwdata_q <= bus.dwdata;
                            mbe_q    <= bus.dbe;
                            mwe_q    <= bus.dwe;
                            state_q  <= ST_DBUSY;
                        end else begin
                            maddr_q  <= bus.iaddr;
                            mwdata_q <= '0;
                            mbe_q    <= IFETCH_BE;
                            mwe_q    <= 1'b0;
                            state_q  <= ST_IBUSY;
                        end
                    end
                end
                ST_IBUSY, ST_DBUSY: begin
                    if (bus.mack) begin
                        if (state_q == ST_IBUSY) begin
                            irdata_q <= bus.mrdata;
                        end else if (!mwe_q) begin
                            drdata_q <= bus.mrdata;
                        end
                        idone_q <= (state_q == ST_IBUSY);
                        ddone_q <= (state_q == ST_DBUSY);
                        mreq_q  <= 1'b0;
                        mwe_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        // Abort on the cycle the counter reaches all-ones;
                        // the requester is released with its data untouched.
                        if (cnt_d == '1) begin
                            tmo_q   <= 1'b1;
                            idone_q <= (state_q == ST_IBUSY);
                            ddone_q <= (state_q == ST_DBUSY);
                            mreq_q  <= 1'b0;
                            mwe_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mreq    = mreq_q;
    assign bus.mwe     = mwe_q;
    assign bus.maddr   = maddr_q;
    assign bus.mwdata  = mwdata_q;
    assign bus.mbe     = mbe_q;
    assign bus.idone   = idone_q;
    assign bus.ddone   = ddone_q;
    assign bus.irdata  = irdata_q;
    assign bus.drdata  = drdata_q;
    assign bus.tmo_err = tmo_q;
    assign bus.istall  = bus.ireq & ~idone_q;
    assign bus.dstall  = bus.dreq & ~ddone_q;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized self-checking bench for mem_arb against a transaction-level model.
module tb_mem_arb;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_arb_if bus ();

    mem_arb #(.TMO_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state: pending requests, their captured fields,
    // last served side, last completed read data per side, timeout flag.
    bit          pi, pd, last_d, m_tmo, dwe_m;
    logic [31:0] ia, da, dwd, m_ir, m_dr;
    logic [3:0]  dbe_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post_i(input logic [31:0] a);
        bus.ireq  = 1'b1;
        bus.iaddr = a;
        pi = 1'b1;
        ia = a;
    endtask

    task automatic post_d(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        bus.dreq   = 1'b1;
        bus.dwe    = we;
        bus.daddr  = a;
        bus.dwdata = wd;
        bus.dbe    = be;
        pd    = 1'b1;
        dwe_m = we;
        da    = a;
        dwd   = wd;
        dbe_m = be;
    endtask

    task automatic model_reset();
        last_d = 1'b0;
        m_ir   = '0;
        m_dr   = '0;
        m_tmo  = 1'b0;
    endtask

    // Serve one transaction: the model picks the winner, the bench acts as
    // memory with 'dly' wait cycles, then the done pulse and data are checked.
    task automatic txn(input int dly, input bit drop, input bit stray, input logic [31:0] rdat);
        bit sd;
        sd = (pi && pd) ? !last_d : pd;
        tick();
        check("grant_mreq", bus.mreq, 1);
        check("maddr", bus.maddr, sd ? da : ia);
        check("mwe", bus.mwe, sd ? dwe_m : 1'b0);
        check("mbe", bus.mbe, sd ? dbe_m : 4'hF);
        if (sd) check("mwdata", bus.mwdata, dwd);
        if (drop) begin
            if (sd) begin bus.dreq = 1'b0; pd = 1'b0; end
            else    begin bus.ireq = 1'b0; pi = 1'b0; end
        end
        #1;
        for (int k = 0; k < dly; k++) begin
            check("istall_busy", bus.istall, pi);
            check("dstall_busy", bus.dstall, pd);
            tick();
            check("mreq_hold", bus.mreq, 1);
            check("mwe_hold", bus.mwe, sd ? dwe_m : 1'b0);
            check("busy_no_done", {bus.idone, bus.ddone}, 2'b00);
        end
        bus.mack   = 1'b1;
        bus.mrdata = rdat;
        tick();
        bus.mack = 1'b0;
        if (!sd)         m_ir = rdat;
        else if (!dwe_m) m_dr = rdat;
        last_d = sd;
        check("idone", bus.idone, !sd);
        check("ddone", bus.ddone, sd);
        check("irdata", bus.irdata, m_ir);
        check("drdata", bus.drdata, m_dr);
        check("done_mreq", bus.mreq, 0);
        check("tmo_err", bus.tmo_err, m_tmo);
        check("istall_done", bus.istall, pi && sd);
        check("dstall_done", bus.dstall, pd && !sd);
        if (sd) begin bus.dreq = 1'b0; pd = 1'b0; end
        else    begin bus.ireq = 1'b0; pi = 1'b0; end
        if (stray) begin
            bus.mack   = 1'b1;
            bus.mrdata = ~rdat;
        end
        tick();
        bus.mack = 1'b0;
        check("done_once", {bus.idone, bus.ddone}, 2'b00);
        check("irdata_hold", bus.irdata, m_ir);
        check("drdata_hold", bus.drdata, m_dr);
        check("idle_mreq", bus.mreq, 0);
        if (drop && !pi && !pd) begin
            tick();
            check("no_regrant", bus.mreq, 0);
        end
    endtask

    initial begin
        int cnt;
        bus.ireq = 0; bus.iaddr = '0; bus.dreq = 0; bus.dwe = 0;
        bus.daddr = '0; bus.dwdata = '0; bus.dbe = '0;
        bus.mack = 0; bus.mrdata = '0;
        pi = 0; pd = 0; dwe_m = 0; ia = '0; da = '0; dwd = '0; dbe_m = '0;
        model_reset();

        repeat (2) tick();
        check("rst_mreq", bus.mreq, 0);
        check("rst_mwe", bus.mwe, 0);
        check("rst_done", {bus.idone, bus.ddone}, 2'b00);
        check("rst_tmo", bus.tmo_err, 0);
        check("rst_irdata", bus.irdata, 0);
        check("rst_drdata", bus.drdata, 0);
        check("rst_maddr", bus.maddr, 0);
        check("rst_mwdata", bus.mwdata, 0);
        check("rst_mbe", bus.mbe, 0);
        reset = 1'b0;
        tick();

        // Single instruction fill with minimum latency
        post_i(32'h40);
        #1;
        check("istall_req", bus.istall, 1);
        txn(0, 0, 0, 32'h2002000A);

        // Simultaneous requests: round-robin order from the model
        post_i(32'h100);
        post_d(1'b0, 32'h200, 32'h0, 4'hF);
        txn(0, 0, 0, 32'h11112222);
        txn(1, 0, 0, 32'h33334444);
        post_i(32'h104);
        post_d(1'b0, 32'h204, 32'h0, 4'hF);
        txn(0, 0, 1, 32'h55556666);
        txn(0, 0, 0, 32'h77778888);

        // Byte store leaves load data untouched
        post_d(1'b1, 32'h80, 32'hDEADBEEF, 4'h1);
        txn(2, 0, 0, 32'hA5A5A5A5);

        // Request dropped right after grant
        post_i(32'h44);
        txn(3, 1, 0, 32'hCAFEF00D);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            if (!pi && $urandom_range(0, 1) == 1) post_i($urandom);
            if (!pd && ($urandom_range(0, 1) == 1 || !pi))
                post_d($urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15)));
            txn($urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, $urandom);
        end
        while (pi || pd) txn(0, 0, 0, $urandom);

        // Ack timeout: mreq for 255 cycles, then release with sticky error
        post_d(1'b0, 32'hC0, 32'h0, 4'hF);
        tick();
        check("tmo_grant", bus.mreq, 1);
        cnt = 1;
        while (cnt < 400) begin
            tick();
            if (!bus.mreq) break;
            cnt++;
        end
        check("tmo_cycles", cnt, 255);
        check("tmo_set", bus.tmo_err, 1);
        check("tmo_ddone", bus.ddone, 1);
        check("tmo_idone", bus.idone, 0);
        check("tmo_drdata", bus.drdata, m_dr);
        m_tmo = 1'b1;
        last_d = 1'b1;
        bus.dreq = 1'b0;
        pd = 1'b0;
        tick();
        check("tmo_sticky", bus.tmo_err, 1);
        check("tmo_done_once", bus.ddone, 0);
        post_i(32'h48);
        txn(1, 0, 0, $urandom);

        // Reset in the middle of a data transaction
        post_d(1'b1, 32'h300, $urandom, 4'h3);
        tick();
        check("rstmid_grant", bus.mreq, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_mreq", bus.mreq, 0);
        check("rstmid_mwe", bus.mwe, 0);
        check("rstmid_tmo", bus.tmo_err, 0);
        tick();
        tick();
        reset = 1'b0;
        bus.dreq = 1'b0;
        pd = 1'b0;
        model_reset();
        tick();
        check("rstmid_no_done", {bus.idone, bus.ddone}, 2'b00);
        check("rstmid_idle", bus.mreq, 0);
        check("rstmid_drdata", bus.drdata, 0);
        post_i(32'h400);
        post_d(1'b0, 32'h500, 32'h0, 4'hC);
        txn(0, 0, 0, $urandom);
        txn(2, 0, 0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
